nfca_tx_framer: RTL and testbench

Parametrised NFC-A (ISO14443-3A) PCD transmit framer. Sits between the command-generation logic, an AXI-Stream-like byte sink, and the bit modulator (tx_req/tx_en/tx_bit). It buffers one frame and emits S bit, data bits LSB-first with odd parity, optional CRC_A and E bit. Compared with the fixed-depth framer, it adds:
- configurable buffer depth and CRC preset;
- a per-frame CRC/parity mode;
- an overflow indication, a busy output and a completion pulse.

---
 rtl/nfca_tx_framer_if.sv | 12 +
 rtl/nfca_tx_framer.sv | 238 +++++++++++++++++++++++
 tb/tb_nfca_tx_framer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nfca_tx_framer_if.sv
// Byte-stream handshake from the command generator into the NFC-A transmit framer.
interface nfca_tx_framer_if;
  logic       tx_tvalid;
  logic       tx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tlast;
  logic [2:0] tx_tlastb;
  logic [1:0] tx_tmode;

  modport master (output tx_tvalid, tx_tdata, tx_tlast, tx_tlastb, tx_tmode, input tx_tready);
  modport slave  (input tx_tvalid, tx_tdata, tx_tlast, tx_tlastb, tx_tmode, output tx_tready);
endinterface

// File: rtl/nfca_tx_framer.sv
// NFC-A PCD transmit framer: buffers one frame, then serialises S, data with odd parity,
// optional CRC_A and E towards the bit modulator, one bit per tx_req.
module nfca_tx_framer #(
  parameter int unsigned AW         = 12,
  parameter logic [15:0] CRC_INIT   = 16'h6363,
  parameter bit          AUTO_SHORT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  nfca_tx_framer_if.slave        s_tx,
  input  logic                   tx_req,
  output logic                   tx_en,
  output logic                   tx_bit,
  output logic [2:0]             remainb,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);
  typedef enum logic [2:0] {
    ST_ACCEPT, ST_START, ST_LOAD, ST_SHIFT, ST_CRC, ST_END, ST_DRAIN
  } state_t;

  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_MAX  = {AW{1'b1}};

  // Reflected CRC_A update (poly x^16+x^12+x^5+1), data bits LSB first.
  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = {1'b0, c[15:1]} ^ 16'h8408;
      else             c = {1'b0, c[15:1]};
    end
    return c;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic is_short_cmd(input logic [7:0] b);
    return (b == 8'h26) || (b == 8'h52) || (b == 8'h35) ||
           (b[7:4] == 4'h4) || (b[7:3] == 5'b01111);
  endfunction

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_q;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [15:0]   crc_q, crc_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic [2:0]    lastb_q, lastb_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    first_q, first_d, second_q, second_d;
  logic [17:0]   sr_q, sr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          crc_sent_q, crc_sent_d;
  logic          tready_q, tready_d;
  logic          tx_en_q, tx_en_d, tx_bit_q, tx_bit_d;
  logic [2:0]    remainb_q, remainb_d;
  logic          busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

  logic beat_s, full_s, incomplete_s, short_s, sel_s, crc_en_s, last_byte_s;

  assign beat_s       = s_tx.tx_tvalid & tready_q;
  assign full_s       = (wptr_q == PTR_MAX);
  assign incomplete_s = (lastb_q != 3'd7);
  assign short_s      = AUTO_SHORT && (mode_q == 2'd0) && is_short_cmd(first_q);
  assign sel_s        = (first_q == 8'h93) || (first_q == 8'h95) || (first_q == 8'h97);
  assign last_byte_s  = ((rptr_q + PTR_ONE) == wptr_q);

  // A select with second byte 0x70 is the full SELECT and carries CRC; a frame of
  // one byte has no second byte, so second_q must not be trusted there.
  always_comb begin
    case (mode_q)
      2'd0:    crc_en_s = !incomplete_s && !short_s &&
                          (!sel_s || ((wptr_q > PTR_ONE) && (second_q == 8'h70)));
      2'd1:    crc_en_s = !incomplete_s;
      default: crc_en_s = 1'b0;
    endcase
  end

  // Frame buffer with registered read port.
  always_ff @(posedge clk) begin
    if (beat_s && !full_s) mem[wptr_q] <= s_tx.tx_tdata;
    rdata_q <= mem[rptr_q];
  end

  // Next-state and next-output logic for the framer FSM.
  always_comb begin
    state_d    = state_q;    wptr_d     = wptr_q;     rptr_d   = rptr_q;
    crc_d      = crc_q;      ovf_flag_d = ovf_flag_q; lastb_d  = lastb_q;
    mode_d     = mode_q;     first_d    = first_q;    second_d = second_q;
    sr_d       = sr_q;       cnt_d      = cnt_q;      crc_sent_d = crc_sent_q;
    tx_en_d    = tx_en_q;    tx_bit_d   = tx_bit_q;   remainb_d  = remainb_q;
    busy_d     = busy_q;     done_d     = 1'b0;       ovf_d      = 1'b0;
    tready_d   = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        tready_d = 1'b1;
        if (beat_s) begin
          if (full_s) begin
            ovf_flag_d = 1'b1;
          end else begin
            wptr_d   = wptr_q + PTR_ONE;
            crc_d    = crc_a_byte(crc_q, s_tx.tx_tdata);
            first_d  = (wptr_q == PTR_ZERO) ? s_tx.tx_tdata : first_q;
            second_d = (wptr_q == PTR_ONE)  ? s_tx.tx_tdata : second_q;
          end
          if (s_tx.tx_tlast) begin
            lastb_d = s_tx.tx_tlastb;
            mode_d  = s_tx.tx_tmode;
            if (ovf_flag_q || full_s) begin
              wptr_d     = PTR_ZERO;
              crc_d      = CRC_INIT;
              ovf_flag_d = 1'b0;
              ovf_d      = 1'b1;
            end else begin
              tready_d = 1'b0;
              busy_d   = 1'b1;
              state_d  = ST_START;
            end
          end else begin
            lastb_d = lastb_q;
          end
        end else begin
          tready_d = 1'b1;
        end
      end
      ST_START: begin
        if (tx_req) begin
          tx_en_d  = 1'b1;
          tx_bit_d = 1'b0;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_START;
        end
      end
      ST_LOAD: begin
        rptr_d     = rptr_q + PTR_ONE;
        crc_sent_d = 1'b0;
        state_d    = ST_SHIFT;
        if (last_byte_s && incomplete_s) begin
          sr_d  = {10'd0, rdata_q};
          cnt_d = {2'b00, lastb_q} + 5'd1;
        end else if (mode_q == 2'd3) begin
          sr_d  = {10'd0, rdata_q};
          cnt_d = 5'd8;
        end else if (short_s && (rptr_q == PTR_ZERO)) begin
          sr_d  = {10'd0, rdata_q};
          cnt_d = 5'd7;
        end else begin
          sr_d  = {9'd0, odd_par(rdata_q), rdata_q};
          cnt_d = 5'd9;
        end
      end
      ST_SHIFT: begin
        if (tx_req) begin
          tx_en_d  = 1'b1;
          tx_bit_d = sr_q[0];
          sr_d     = {1'b0, sr_q[17:1]};
          cnt_d    = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            if (rptr_q != wptr_q)          state_d = ST_LOAD;
            else if (crc_en_s && !crc_sent_q) state_d = ST_CRC;
            else                           state_d = ST_END;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_CRC: begin
        sr_d       = {odd_par(crc_q[15:8]), crc_q[15:8], odd_par(crc_q[7:0]), crc_q[7:0]};
        cnt_d      = 5'd18;
        crc_sent_d = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_END: begin
        if (tx_req) begin
          tx_en_d   = 1'b1;
          tx_bit_d  = 1'b0;
          remainb_d = incomplete_s ? (lastb_q + 3'd1) : 3'd0;
          state_d   = ST_DRAIN;
        end else begin
          state_d = ST_END;
        end
      end
      ST_DRAIN: begin
        if (tx_req) begin
          tx_en_d  = 1'b0;
          tx_bit_d = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          wptr_d   = PTR_ZERO;
          rptr_d   = PTR_ZERO;
          crc_d    = CRC_INIT;
          state_d  = ST_ACCEPT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_ACCEPT;  wptr_q  <= PTR_ZERO; rptr_q <= PTR_ZERO;
      crc_q    <= CRC_INIT;   ovf_flag_q <= 1'b0;  lastb_q <= 3'd7;
      mode_q   <= 2'd0;       first_q <= 8'd0;     second_q <= 8'd0;
      sr_q     <= 18'd0;      cnt_q   <= 5'd0;     crc_sent_q <= 1'b0;
      tready_q <= 1'b0;       tx_en_q <= 1'b0;     tx_bit_q <= 1'b0;
      remainb_q <= 3'd0;      busy_q  <= 1'b0;     done_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;    wptr_q  <= wptr_d;   rptr_q <= rptr_d;
      crc_q    <= crc_d;      ovf_flag_q <= ovf_flag_d; lastb_q <= lastb_d;
      mode_q   <= mode_d;     first_q <= first_d;  second_q <= second_d;
      sr_q     <= sr_d;       cnt_q   <= cnt_d;    crc_sent_q <= crc_sent_d;
      tready_q <= tready_d;   tx_en_q <= tx_en_d;  tx_bit_q <= tx_bit_d;
      remainb_q <= remainb_d; busy_q  <= busy_d;   done_q <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign s_tx.tx_tready = tready_q;
  assign tx_en   = tx_en_q;
  assign tx_bit  = tx_bit_q;
  assign remainb = remainb_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_nfca_tx_framer.sv
// Bench for nfca_tx_framer: directed NFC-A frames plus random frames checked against
// a bit-list reference built from the framing rules and a byte-wise CRC_A.
module tb_nfca_tx_framer;
  localparam int AW = 4;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       tx_req = 1'b0;
  logic       tx_en, tx_bit, busy, done, ovf;
  logic [2:0] remainb;

  int checks = 0;
  int fails  = 0;

  logic [7:0] fb [$];
  logic       exp_bits [$];
  logic       got_bits [$];
  logic [2:0] exp_remain;

  nfca_tx_framer_if bus ();

  nfca_tx_framer #(.AW(AW), .CRC_INIT(16'h6363), .AUTO_SHORT(1'b1)) dut (
    .clk(clk), .rstn(rstn), .s_tx(bus), .tx_req(tx_req), .tx_en(tx_en),
    .tx_bit(tx_bit), .remainb(remainb), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_short(input logic [7:0] b);
    return (b == 8'h26) || (b == 8'h52) || (b == 8'h35) ||
           (b >= 8'h40 && b <= 8'h4F) || (b >= 8'h78 && b <= 8'h7F);
  endfunction

  // Byte-wise CRC_A over the whole frame buffer.
  function automatic logic [15:0] crc_ref();
    int c, ch;
    c = 32'h6363;
    foreach (fb[i]) begin
      ch = (int'(fb[i]) ^ c) & 32'hFF;
      ch = (ch ^ (ch << 4)) & 32'hFF;
      c  = ((c >> 8) ^ (ch << 8) ^ (ch << 3) ^ (ch >> 4)) & 32'hFFFF;
    end
    return c[15:0];
  endfunction

  task automatic push_byte(input logic [7:0] b, input int nb);
    for (int k = 0; k < nb; k++)
      exp_bits.push_back(k < 8 ? b[k] : ($countones(b) % 2 == 0));
  endtask

  task automatic build_exp(input logic [2:0] lb, input logic [1:0] md);
    int n, nb;
    bit incomplete, shrt, crc_on;
    logic [15:0] c;
    n = fb.size();
    incomplete = (lb != 3'd7);
    shrt = (md == 2'd0) && is_short(fb[0]);
    if (md == 2'd0) begin
      if (shrt || incomplete) crc_on = 1'b0;
      else if (fb[0] == 8'h93 || fb[0] == 8'h95 || fb[0] == 8'h97)
        crc_on = (n >= 2) && (fb[1] == 8'h70);
      else crc_on = 1'b1;
    end else begin
      crc_on = (md == 2'd1) && !incomplete;
    end
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && incomplete) nb = int'(lb) + 1;
      else if (md == 2'd3)          nb = 8;
      else if (shrt && i == 0)      nb = 7;
      else                          nb = 9;
      push_byte(fb[i], nb);
    end
    if (crc_on) begin
      c = crc_ref();
      push_byte(c[7:0], 9);
      push_byte(c[15:8], 9);
    end
    exp_bits.push_back(1'b0);
    exp_remain = incomplete ? (lb + 3'd1) : 3'd0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic [2:0] lb,
                           input logic [1:0] md);
    int n;
    n = 0;
    bus.tx_tvalid = 1'b1; bus.tx_tdata = d; bus.tx_tlast = last;
    bus.tx_tlastb = lb;   bus.tx_tmode = md;
    while (bus.tx_tready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("tready_timeout", 32'd1, 32'd0);
    tick();
    bus.tx_tvalid = 1'b0;
    bus.tx_tlast  = 1'b0;
  endtask

  task automatic pulse();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [2:0] lb, input logic [1:0] md,
                           input int want_bits);
    int n_p, diff;
    bit fin;
    build_exp(lb, md);
    for (int i = 0; i < fb.size(); i++) send_beat(fb[i], (i == fb.size() - 1), lb, md);
    chk({name, ":tready_low"}, 32'(tready_now()), 32'd0);
    chk({name, ":busy_high"}, 32'(busy), 32'd1);
    got_bits.delete();
    fin = 1'b0;
    n_p = 0;
    while (!fin && n_p < 400) begin
      pulse();
      n_p++;
      if (tx_en === 1'b1) begin
        got_bits.push_back(tx_bit);
        repeat (3) tick();
      end else begin
        fin = 1'b1;
        chk({name, ":done"}, 32'(done), 32'd1);
        chk({name, ":busy_end"}, 32'(busy), 32'd0);
        chk({name, ":remainb"}, 32'(remainb), 32'(exp_remain));
        chk({name, ":tready_at_done"}, 32'(tready_now()), 32'd0);
        tick();
        chk({name, ":tready_after"}, 32'(tready_now()), 32'd1);
        chk({name, ":done_once"}, 32'(done), 32'd0);
      end
    end
    chk({name, ":finished"}, 32'(fin), 32'd1);
    chk({name, ":nbits"}, 32'(got_bits.size()), 32'(exp_bits.size()));
    if (want_bits > 0) chk({name, ":nbits_air"}, 32'(got_bits.size()), 32'(want_bits));
    diff = exp_bits.size();
    for (int i = exp_bits.size() - 1; i >= 0; i--)
      if (i >= got_bits.size() || got_bits[i] !== exp_bits[i]) diff = i;
    chk({name, ":first_bad_bit"}, 32'(diff), 32'(exp_bits.size()));
  endtask

  function automatic logic tready_now();
    return bus.tx_tready;
  endfunction

  initial begin
    bus.tx_tvalid = 1'b0; bus.tx_tdata = 8'd0; bus.tx_tlast = 1'b0;
    bus.tx_tlastb = 3'd7; bus.tx_tmode = 2'd0;
    repeat (3) tick();
    chk("rst:tready", 32'(tready_now()), 32'd0);
    chk("rst:tx_en", 32'(tx_en), 32'd0);
    chk("rst:tx_bit", 32'(tx_bit), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:ovf", 32'(ovf), 32'd0);
    chk("rst:remainb", 32'(remainb), 32'd0);
    rstn = 1'b1;
    chk("rst:tready_hold", 32'(tready_now()), 32'd0);
    tick();
    chk("rst:tready_up", 32'(tready_now()), 32'd1);

    fb = '{8'h26};             run_frame("reqa", 3'd7, 2'd0, 9);
    fb = '{8'h93, 8'h20};       run_frame("anticoll", 3'd7, 2'd0, 20);
    fb = '{8'h30, 8'h00};       run_frame("read", 3'd7, 2'd0, 38);
    fb = '{8'h93, 8'h25, 8'h0F}; run_frame("incomplete", 3'd2, 2'd0, 23);
    fb = '{8'h30, 8'h00};       run_frame("mode2", 3'd7, 2'd2, 20);
    fb = '{8'h93, 8'h20};       run_frame("mode1", 3'd7, 2'd1, 38);

    // 16-byte frame into a 15-byte buffer.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("ovf:before", 32'(ovf), 32'd0);
      send_beat(8'($urandom), (i == 15), 3'd7, 2'd0);
    end
    chk("ovf:pulse", 32'(ovf), 32'd1);
    chk("ovf:tready", 32'(tready_now()), 32'd1);
    chk("ovf:busy", 32'(busy), 32'd0);
    tick();
    chk("ovf:single", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      chk("ovf:no_tx_en", 32'(tx_en), 32'd0);
      repeat (3) tick();
    end
    fb = '{8'h26};             run_frame("reqa_after_ovf", 3'd7, 2'd0, 9);

    for (int f = 0; f < 14; f++) begin
      int len, sel;
      logic [1:0] md;
      logic [2:0] lb;
      len = $urandom_range(1, 15);
      md  = 2'($urandom_range(0, 3));
      fb.delete();
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      sel = $urandom_range(0, 3);
      if (len == 1 && sel == 0) begin
        case ($urandom_range(0, 3))
          0:       fb[0] = 8'h26;
          1:       fb[0] = 8'h52;
          2:       fb[0] = 8'h40 | 8'($urandom_range(0, 15));
          default: fb[0] = 8'h78 | 8'($urandom_range(0, 7));
        endcase
      end else if (len > 1 && sel == 1) begin
        fb[0] = 8'h93 + 8'(2 * $urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) fb[1] = 8'h70;
      end
      if (len > 1 && is_short(fb[0])) fb[0] = fb[0] | 8'h80;
      lb = (len > 1 && $urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 6)) : 3'd7;
      run_frame("rand", lb, md, 0);
    end

    // Reset in the middle of a frame.
    fb = '{8'h30, 8'h00};
    send_beat(8'h30, 1'b0, 3'd7, 2'd0);
    send_beat(8'h00, 1'b1, 3'd7, 2'd0);
    for (int i = 0; i < 5; i++) begin
      pulse();
      repeat (3) tick();
    end
    chk("midrst:tx_en_before", 32'(tx_en), 32'd1);
    rstn = 1'b0;
    tick();
    chk("midrst:tx_en", 32'(tx_en), 32'd0);
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:tready", 32'(tready_now()), 32'd0);
    chk("midrst:done", 32'(done), 32'd0);
    tick();
    rstn = 1'b1;
    chk("midrst:tready_hold", 32'(tready_now()), 32'd0);
    tick();
    chk("midrst:tready_up", 32'(tready_now()), 32'd1);
    fb = '{8'h26};             run_frame("reqa_after_rst", 3'd7, 2'd0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
